// File: rtl/bus_bridge.sv
// ---------------------------------------------------------------------------
// bus_bridge
//
// Purpose:
//   Sits between the CPU MEM stage and the data RAM / board peripherals.
//   Each bus access is decoded either to DRAM or to a peripheral register
//   window at 0xFFFFF000. Read data is returned combinationally so the
//   MEM/WB register captures it in the same cycle. The bridge also owns the
//   LED register, the 7-segment scanner and the switch/button synchronizers.
//
// Optional feature:
//   BRIDGE_TIMER_EN - when defined, adds a free-running TIMER register
//   (offset 0x020) and its control register TCTRL (offset 0x024). When
//   undefined, both offsets behave as unmapped and no counter is built.
//
// Ports:
//   cpu_clk    in   system clock, rising edge
//   cpu_rst    in   asynchronous active-low reset
//   Bus_addr   in   32-bit byte address from MEM stage
//   Bus_wen    in   write enable from MEM stage
//   Bus_wdata  in   32-bit write data
//   Bus_rdata  out  32-bit read data (combinational)
//   dram_addr  out  DRAM word address (DRAM_AW bits)
//   dram_we    out  DRAM write enable
//   dram_wdata out  DRAM write data (pass-through of Bus_wdata)
//   dram_rdata in   DRAM asynchronous read data
//   sw         in   24 board switches (asynchronous)
//   btn        in   5 board buttons (asynchronous)
//   led        out  24-bit LED register
//   seg_en     out  active-low one-hot digit enables
//   seg_dig    out  active-low segments {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bus_bridge #(
  parameter int DRAM_AW  = 16,
  parameter int SCAN_DIV = 20000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         seg_en,
  output logic [7:0]         seg_dig
);

  localparam int CW = $clog2(SCAN_DIV);

  logic          w_periph;
  logic [11:0]   w_off;
  logic          w_wrDisp;
  logic          w_wrLed;
  logic [31:0]   r_disp;
  logic [23:0]   r_led;
  logic [23:0]   r_swSync1;
  logic [23:0]   r_swSync2;
  logic [4:0]    r_btnSync1;
  logic [4:0]    r_btnSync2;
  logic [CW-1:0] r_scanCnt;
  logic [2:0]    r_digIdx;
  logic [7:0]    r_segDig;
  logic [3:0]    w_nibble;

  // Active-low 7-segment pattern for one hex digit, decimal point off.
  function automatic logic [7:0] hexToSeg(input logic [3:0] val);
    logic [7:0] seg;
    case (val)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Address decode: the top 20 bits select the peripheral window, anything
  // else goes to DRAM. DRAM never sees a write aimed at a peripheral.
  assign w_periph   = (Bus_addr[31:12] == 20'hFFFFF);
  assign w_off      = Bus_addr[11:0];
  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_we    = Bus_wen & ~w_periph;
  assign dram_wdata = Bus_wdata;

  assign w_wrDisp = Bus_wen & w_periph & (w_off == 12'h000);
  assign w_wrLed  = Bus_wen & w_periph & (w_off == 12'h060);

  assign led      = r_led;
  assign seg_en   = ~(8'b1 << r_digIdx);
  assign seg_dig  = r_segDig;
  assign w_nibble = r_disp[{r_digIdx, 2'b00} +: 4];

`ifdef BRIDGE_TIMER_EN
  logic        w_wrTimer;
  logic        w_wrTctrl;
  logic [31:0] r_timer;
  logic        r_tctrl;

  assign w_wrTimer = Bus_wen & w_periph & (w_off == 12'h020);
  assign w_wrTctrl = Bus_wen & w_periph & (w_off == 12'h024);

  // Free-running timer; a bus write in the same cycle as an increment
  // takes priority so software always sees the value it wrote.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_timer <= 32'h0;
      r_tctrl <= 1'b0;
    end else begin
      if (w_wrTimer)
        r_timer <= Bus_wdata;
      else if (r_tctrl)
        r_timer <= r_timer + 32'h1;
      if (w_wrTctrl)
        r_tctrl <= Bus_wdata[0];
    end
  end
`endif

  // Zero-latency read mux; valid regardless of Bus_wen so a store cycle
  // still presents the pre-write register value.
  always_comb begin
    Bus_rdata = 32'h0;
    if (!w_periph) begin
      Bus_rdata = dram_rdata;
    end else begin
      case (w_off)
        12'h000: Bus_rdata = r_disp;
        12'h060: Bus_rdata = {8'h0, r_led};
        12'h070: Bus_rdata = {8'h0, r_swSync2};
        12'h078: Bus_rdata = {27'h0, r_btnSync2};
`ifdef BRIDGE_TIMER_EN
        12'h020: Bus_rdata = r_timer;
        12'h024: Bus_rdata = {31'h0, r_tctrl};
`endif
        default: Bus_rdata = 32'h0;
      endcase
    end
  end

  // Writable peripheral registers plus the two-flop synchronizers for the
  // asynchronous board inputs.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_disp     <= 32'h0;
      r_led      <= 24'h0;
      r_swSync1  <= 24'h0;
      r_swSync2  <= 24'h0;
      r_btnSync1 <= 5'h0;
      r_btnSync2 <= 5'h0;
    end else begin
      if (w_wrDisp)
        r_disp <= Bus_wdata;
      if (w_wrLed)
        r_led <= Bus_wdata[23:0];
      r_swSync1  <= sw;
      r_swSync2  <= r_swSync1;
      r_btnSync1 <= btn;
      r_btnSync2 <= r_btnSync1;
    end
  end

  // Display scanner: each digit is lit for SCAN_DIV cycles, then the index
  // advances. Segments are registered from the current DISP value, so a
  // DISP write shows up one cycle after the register loads, and the scan
  // position is never disturbed by bus traffic.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_scanCnt <= '0;
      r_digIdx  <= 3'd0;
      r_segDig  <= 8'hC0;
    end else begin
      if (r_scanCnt == CW'(SCAN_DIV - 1)) begin
        r_scanCnt <= '0;
        r_digIdx  <= r_digIdx + 3'd1;
      end else begin
        r_scanCnt <= r_scanCnt + CW'(1);
      end
      r_segDig <= hexToSeg(w_nibble);
    end
  end

endmodule

// File: doc/bus_bridge.md
Name: bus_bridge

Overview:
- Sits directly downstream of the CPU core's MEM stage, between the core's Bus_* interface and the data RAM plus board peripherals.
- Decodes each access and routes it to DRAM or a peripheral register.
- Returns read data in the same cycle, which the MEM/WB register captures.
- Owns the LED, 7-segment scan, switch/button synchronizer and an optional timer.

Parameters:
- DRAM_AW, 16, DRAM word-address width; dram_addr = Bus_addr[DRAM_AW+1:2].
- SCAN_DIV, 20000, cpu_clk cycles each 7-seg digit is lit; must be ≥2.

Ports:
- cpu_clk  in  1  system clock; all state updates on the rising edge.
- cpu_rst  in  1  asynchronous, active-low reset.
- Bus_addr  in  32  byte address from the MEM stage.
- Bus_wen  in  1  write enable from the MEM stage.
- Bus_wdata  in  32  write data.
- Bus_rdata  out  32  read data, combinational.
- dram_addr  out  DRAM_AW  word address to DRAM.
- dram_we  out  1  DRAM write enable.
- dram_wdata  out  32  equals Bus_wdata.
- dram_rdata  in  32  asynchronous-read DRAM output.
- sw  in  24  board switches, asynchronous.
- btn  in  5  board buttons, asynchronous.
- led  out  24  LED register.
- seg_en  out  8  digit enables, active-low one-hot.
- seg_dig  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Decode:
  - periph = (Bus_addr[31:12] == 20'hFFFFF); otherwise the access is a DRAM access.
  - Peripheral selection uses Bus_addr[11:0].
- Peripheral register map:
  - 0x000 DISP (32-bit, R/W)
  - 0x020 TIMER (32-bit, R/W)
  - 0x024 TCTRL (bit0 = enable, R/W; other bits read 0)
  - 0x060 LED (24-bit, R/W; upper bits read 0)
  - 0x070 SW (read-only)
  - 0x078 BTN (read-only)
- Writes:
  - dram_we = Bus_wen & ~periph.
  - Peripheral registers load Bus_wdata on the rising edge where Bus_wen=1 and the address matches.
  - Writes to SW, BTN or unmapped offsets are ignored.
- Reads, zero-latency combinational:
  - DRAM access: Bus_rdata = dram_rdata.
  - Peripheral access: Bus_rdata = the register value, zero-extended.
  - Unmapped peripheral offset: Bus_rdata = 0.
  - Bus_rdata is valid whether or not Bus_wen is asserted.
- Synchronizer:
  - sw and btn each pass through 2 flops; SW/BTN reads return the second stage.
  - Input-to-read latency is 2 rising edges.
- 7-seg scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, dig_idx advances 0..7 and wraps 7→0.
  - seg_en = ~(8'b1 << dig_idx).
  - seg_dig = hex decode of DISP[4*dig_idx+3 : 4*dig_idx], registered, with dp=1.
  - Decode table: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E.
  - A DISP write is visible on seg_dig one cycle later; the scan position is not disturbed.
- Reset values (asynchronous, on cpu_rst low):
  - led=0, DISP=0, TIMER=0, TCTRL=0.
  - Sync flops = 0, scan_cnt=0, dig_idx=0.
  - seg_en=8'hFE, seg_dig=8'hC0.
  - Reset asserted mid-scan or mid-count returns immediately to these values.
- Simultaneous events:
  - A DRAM write and a peripheral write cannot coincide; there is a single bus.
  - A TIMER write in the same cycle as an increment: the write wins.

Optional Feature:
- Macro: BRIDGE_TIMER_EN.
- Defined:
  - When TCTRL[0]=1, TIMER increments by 1 every cycle.
  - TIMER wraps 32'hFFFFFFFF→0.
  - TIMER and TCTRL are readable and writable.
- Undefined:
  - TIMER and TCTRL do not exist; offsets 0x020 and 0x024 are treated as unmapped (read 0, writes ignored).
  - No counter logic is synthesized.

Test Plan:
- DRAM write/read: write 0x1234_5678 to 0x0000_0010 (Bus_wen=1), then read it. Required: dram_we=1, dram_addr=4, dram_wdata=0x12345678 during the write; Bus_rdata=dram_rdata and dram_we=0 on the read.
- LED: write 0xFFAB_CDEF to 0xFFFF_F060. Required: led=24'hABCDEF after the edge; reading 0xFFFFF060 returns 0x00ABCDEF; dram_we stays 0.
- Switch sync: change sw 0→24'h00_0F0F. Required: reading 0xFFFFF070 returns 0 for 1 edge and 0x00000F0F after the 2nd edge.
- 7-seg (SCAN_DIV=4): write DISP=0x0000_00A5.
  - Digit 0: seg_en=FE, seg_dig=92.
  - After 4 cycles: seg_en=FD, seg_dig=88.
  - Digit 2: seg_dig=C0.
  - dig_idx wraps back to 0 after 32 cycles.
- Timer (BRIDGE_TIMER_EN): write TIMER=0xFFFF_FFFE, then TCTRL=1. Required: TIMER reads 0xFFFFFFFF, then 0 on consecutive cycles; a same-cycle write of 5 loads 5. Without the macro, reading 0xFFFFF020 returns 0.
- Reset: assert cpu_rst=0 asynchronously mid-scan with led≠0. Required: led=0, seg_en=FE and seg_dig=C0 immediately, without waiting for a clock edge.
